// File: rtl/fix2flt_pkg.sv
// Shared types and constants for the fixed-point to half-float converter.
// State encoding uses plain localparams so legacy tools can consume it.
package fix2flt_pkg;

  typedef logic [2:0] fix2flt_state_t;

  localparam fix2flt_state_t ST_IDLE  = 3'd0;
  localparam fix2flt_state_t ST_LD_LO = 3'd1;
  localparam fix2flt_state_t ST_LD_HI = 3'd2;
  localparam fix2flt_state_t ST_NORM  = 3'd3;
  localparam fix2flt_state_t ST_RND   = 3'd4;
  localparam fix2flt_state_t ST_WR_LO = 3'd5;
  localparam fix2flt_state_t ST_WR_HI = 3'd6;

  localparam int unsigned FLT_BIAS  = 15;
  localparam int unsigned FRAC_BITS = 8;

  // A leading one at bit 14 of the magnitude is worth 2^(14-FRAC_BITS).
  localparam logic [4:0] EXP_INIT = 5'(14 + FLT_BIAS - FRAC_BITS);

endpackage

// File: rtl/fix2flt_if.sv
// Start/done handshake plus byte-wide data memory port of the converter.
interface fix2flt_if;

  logic       start;
  logic       done;
  logic [7:0] dm_addr;
  logic [7:0] dm_rd_data;
  logic [7:0] dm_wr_data;
  logic       dm_we;

  modport master (
    input  start,
    input  dm_rd_data,
    output done,
    output dm_addr,
    output dm_wr_data,
    output dm_we
  );

  modport slave (
    output start,
    output dm_rd_data,
    input  done,
    input  dm_addr,
    input  dm_wr_data,
    input  dm_we
  );

endinterface

// File: rtl/fix2flt_round.sv
// Round-to-nearest-even of a normalized 15-bit magnitude into a half-float
// exponent/fraction pair; a zero magnitude yields a zero exponent and fraction.
module fix2flt_round (
  input  logic [14:0] i_m,
  input  logic [4:0]  i_exp,
  output logic [4:0]  o_e,
  output logic [9:0]  o_f
);

  logic        w_g;
  logic        w_st;
  logic        w_up;
  logic [10:0] w_sum;

  always_comb begin
    w_g   = i_m[3];
    w_st  = |i_m[2:0];
    w_up  = w_g & (w_st | i_m[4]);
    // Bit 10 of the sum is the fraction carry that bumps the exponent.
    w_sum = {1'b0, i_m[13:4]} + {10'd0, w_up};
    if (i_m == 15'd0) begin
      o_e = 5'd0;
      o_f = 10'd0;
    end else begin
      o_e = i_exp + {4'd0, w_sum[10]};
      o_f = w_sum[9:0];
    end
  end

endmodule

// File: rtl/fix2flt.sv
// Memory-to-memory engine converting sign-magnitude 8.8 fixed point to half
// float, normalizing one bit per cycle; started by a falling edge of start.
module fix2flt
  import fix2flt_pkg::*;
#(
  parameter logic [7:0] IN_ADDR  = 8'd0,
  parameter logic [7:0] OUT_ADDR = 8'd2
) (
  input logic       clk,
  input logic       reset,
  fix2flt_if.master bus
);

  fix2flt_state_t r_state;
  logic           r_start_q;
  logic           r_done;
  logic           r_s;
  logic [14:0]    r_m;
  logic [4:0]     r_exp;
  logic [15:0]    r_res;

  logic           w_fall;
  logic           w_rise;
  logic [4:0]     w_e;
  logic [9:0]     w_f;

  assign w_fall = r_start_q & ~bus.start;
  assign w_rise = ~r_start_q & bus.start;

  fix2flt_round u_round (
    .i_m   (r_m),
    .i_exp (r_exp),
    .o_e   (w_e),
    .o_f   (w_f)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b0;
      r_done    <= 1'b0;
      r_s       <= 1'b0;
      r_m       <= 15'd0;
      r_exp     <= 5'd0;
      r_res     <= 16'd0;
    end else begin
      r_start_q <= bus.start;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_done  <= 1'b0;
            r_state <= ST_LD_LO;
          end else if (w_rise) begin
            r_done <= 1'b0;
          end
        end
        ST_LD_LO: begin
          r_m[7:0] <= bus.dm_rd_data;
          r_state  <= ST_LD_HI;
        end
        ST_LD_HI: begin
          r_s       <= bus.dm_rd_data[7];
          r_m[14:8] <= bus.dm_rd_data[6:0];
          r_exp     <= EXP_INIT;
          r_state   <= ST_NORM;
        end
        ST_NORM: begin
          if ((r_m == 15'd0) || r_m[14]) begin
            r_state <= ST_RND;
          end else begin
            r_m   <= {r_m[13:0], 1'b0};
            r_exp <= r_exp - 5'd1;
          end
        end
        ST_RND: begin
          r_res   <= {r_s, w_e, w_f};
          r_state <= ST_WR_LO;
        end
        ST_WR_LO: r_state <= ST_WR_HI;
        ST_WR_HI: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port decoded from state so an async reset drops it at once.
  always_comb begin
    bus.dm_addr    = 8'd0;
    bus.dm_we      = 1'b0;
    bus.dm_wr_data = 8'd0;
    case (r_state)
      ST_LD_LO: bus.dm_addr = IN_ADDR;
      ST_LD_HI: bus.dm_addr = IN_ADDR + 8'd1;
      ST_WR_LO: begin
        bus.dm_addr    = OUT_ADDR;
        bus.dm_we      = 1'b1;
        bus.dm_wr_data = r_res[7:0];
      end
      ST_WR_HI: begin
        bus.dm_addr    = OUT_ADDR + 8'd1;
        bus.dm_we      = 1'b1;
        bus.dm_wr_data = r_res[15:8];
      end
      default: ;
    endcase
  end

  assign bus.done = r_done;

endmodule

// File: tb/tb_fix2flt.sv
// Randomized and directed bench for fix2flt against an arithmetic half-float
// reference with latency and write-count checks.
module tb_fix2flt;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] op;
  logic [7:0]  mem [256];
  int          wr_cnt = 0;
  int          bad_wr = 0;
  int          n_checks = 0;
  int          n_errs = 0;

  fix2flt_if u_bus ();

  fix2flt u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_bus.master)
  );

  always #5 clk = ~clk;

  // Operand bytes come from op; everything else from the written memory.
  assign u_bus.dm_rd_data = (u_bus.dm_addr == 8'd0) ? op[7:0] :
                            (u_bus.dm_addr == 8'd1) ? op[15:8] : mem[u_bus.dm_addr];

  always @(posedge clk) begin
    if (u_bus.dm_we) begin
      mem[u_bus.dm_addr] <= u_bus.dm_wr_data;
      wr_cnt <= wr_cnt + 1;
      if (u_bus.dm_addr != 8'd2 && u_bus.dm_addr != 8'd3) bad_wr <= bad_wr + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lead_pos(input int mag);
    int p = -1;
    for (int i = 0; i < 15; i++) if (mag >= (1 << i)) p = i;
    return p;
  endfunction

  // Value = mag * 2^-8 rounded to an 11-bit significand, ties to even.
  function automatic logic [15:0] ref_f2h(input logic [15:0] w);
    int mag, p, q, sh, rem, half;
    logic [4:0] e;
    logic [9:0] f;
    mag = int'(w[14:0]);
    if (mag == 0) return {w[15], 15'd0};
    p = lead_pos(mag);
    if (p <= 10) begin
      q = mag << (10 - p);
    end else begin
      sh   = p - 10;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
    end
    if (q == 2048) begin
      q = 1024;
      p++;
    end
    e = 5'(p + 7);
    f = 10'(q);
    return {w[15], e, f};
  endfunction

  function automatic int ref_lat(input logic [15:0] w);
    int mag = int'(w[14:0]);
    if (mag == 0) return 6;
    return 6 + 14 - lead_pos(mag);
  endfunction

  task automatic start_pulse();
    @(negedge clk) u_bus.start = 1'b1;
    @(negedge clk);
    check_eq("done_clr", 32'(u_bus.done), 32'd0);
    u_bus.start = 1'b0;
  endtask

  task automatic run_conv(input logic [15:0] w, input bit pulse_mid);
    int lat, wr0;
    op  = w;
    wr0 = wr_cnt;
    start_pulse();
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (pulse_mid && n == 6) u_bus.start = 1'b1;
      if (pulse_mid && n == 8) u_bus.start = 1'b0;
      if (u_bus.done) begin
        lat = n - 1;
        break;
      end
    end
    check_eq($sformatf("lat_%h", w), 32'(lat), 32'(ref_lat(w)));
    check_eq($sformatf("wrs_%h", w), 32'(wr_cnt - wr0), 32'd2);
    check_eq($sformatf("res_%h", w), 32'({mem[3], mem[2]}), 32'(ref_f2h(w)));
  endtask

  initial begin
    logic [15:0] prev;
    int wr0;
    u_bus.start = 1'b0;
    op    = 16'h0000;
    reset = 1'b1;
    #1;
    check_eq("rst_done", 32'(u_bus.done), 32'd0);
    check_eq("rst_we", 32'(u_bus.dm_we), 32'd0);
    check_eq("rst_addr", 32'(u_bus.dm_addr), 32'd0);
    check_eq("rst_wdata", 32'(u_bus.dm_wr_data), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_conv(16'h0100, 1'b0);
    run_conv(16'h8180, 1'b0);
    run_conv(16'h0001, 1'b0);
    run_conv(16'h0801, 1'b0);
    run_conv(16'h0803, 1'b0);
    run_conv(16'h7FFF, 1'b0);
    run_conv(16'h8000, 1'b0);
    run_conv(16'h0000, 1'b0);
    check_eq("max_const", 32'(ref_f2h(16'h7FFF)), 32'h5800);

    // Reset lands at E3 of a long conversion.
    prev = {mem[3], mem[2]};
    wr0  = wr_cnt;
    op   = 16'h0001;
    start_pulse();
    for (int n = 1; n <= 4; n++) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_done", 32'(u_bus.done), 32'd0);
    check_eq("mid_rst_we", 32'(u_bus.dm_we), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_rst_wrs", 32'(wr_cnt - wr0), 32'd0);
    check_eq("mid_rst_mem", 32'({mem[3], mem[2]}), 32'(prev));
    @(negedge clk) reset = 1'b0;
    run_conv(16'h0001, 1'b0);

    run_conv(16'h0001, 1'b1);

    for (int i = 0; i < 24; i++) run_conv(16'($urandom), 1'b0);

    check_eq("bad_writes", 32'(bad_wr), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/fix2flt.md
# fix2flt

Sequential converter from sign-magnitude 8.8-style fixed point to IEEE half-precision float. It is the reverse direction of the team's float-to-fixed program block. It reads a 16-bit operand from data memory, normalizes it one bit per cycle, rounds to nearest-even, and writes the 16-bit float back to memory. It sits beside `data_mem` as a synthesizable top-level engine and is started and finished with the standard `start`/`done` handshake.

## Interface
- `IN_ADDR`, default 8'd0: byte address of the operand LSB; the MSB is at `IN_ADDR+1`.
- `OUT_ADDR`, default 8'd2: byte address of the result LSB; the MSB is at `OUT_ADDR+1`.
- `clk`  in  1  single clock; all state changes on the posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  request; a conversion begins on its falling edge.
- `done`  out  1  high when a result has been written; held until `start` next rises.
- `dm_addr`  out  8  data memory byte address.
- `dm_rd_data`  in  8  data memory read data; combinational (valid in the same cycle as `dm_addr`).
- `dm_wr_data`  out  8  data memory write data.
- `dm_we`  out  1  data memory write enable; sampled by memory at posedge.

## Operation
- Input word: `{s, mag[14:0]}`, value = (-1)^s · mag · 2^-8. Output: half float `{s, e[4:0], f[9:0]}`.
- `start_q` register; falling edge = `start_q & ~start` sampled at posedge. Edges while busy are ignored.
- FSM states:
  - IDLE: waits for the start edge, then clears `done` and goes to LD_LO.
  - LD_LO: `dm_addr=IN_ADDR`; capture `mag[7:0]`.
  - LD_HI: `dm_addr=IN_ADDR+1`; capture `s` and `mag[14:8]`; set `exp=21`.
  - NORM: if `m==0` or `m[14]`, go to RND. Otherwise shift `m` left by 1 and decrement `exp`.
  - RND: takes `f=m[13:4]`, `g=m[3]`, `st=|m[2:0]`. Round up iff `g & (st | m[4])`.
    - If `f` overflows on round-up, set `f=0` and `exp+1`.
    - If `m==0`, the result is `{s,15'b0}` (signed zero).
  - WR_LO: `dm_we=1`, `dm_addr=OUT_ADDR`, low byte.
  - WR_HI: `dm_we=1`, `dm_addr=OUT_ADDR+1`, high byte; set `done`; go to IDLE.
- Exponent range is 7..22, so no subnormal, infinity or NaN outputs exist. The maximum input 0x7FFF rounds to 0x5800.
- `exp` is 5 bits unsigned. Bias is 15. The leading-one position p gives `e=p+7` before rounding.

## Timing
- Reset values: `done=0`, `dm_we=0`, `dm_addr=0`, `dm_wr_data=0`, state IDLE, `start_q=0`.
- Let E0 be the edge detecting the falling edge of `start`, and k=14-p the shift count (k=0 for a zero input).
- Schedule relative to E0:
  - LD_LO captures at E1; LD_HI captures at E2.
  - NORM exits at E3+k; RND completes at E4+k.
  - Low byte is written at E5+k.
  - High byte is written and `done` rises at E6+k.
- Total latency is 6..20 cycles.
- `dm_we` is high for exactly two cycles per conversion, with no other memory writes.
- Reset asserted mid-operation: outputs drop asynchronously, no further writes occur, and memory keeps any partial write.
- `start` high at the moment `done` is set: `done` still sets and clears at the next start-rise sample.
- Back-to-back conversions need a new rise and fall of `start`.

## Structure
- `fix2flt_pkg`: state enum `fix2flt_state_t`; constants `FLT_BIAS=15`, `EXP_INIT=21`, `FRAC_BITS=8`.
- One sub-module, `fix2flt_round`: combinational round-to-nearest-even.
  - Inputs: `m[14:0]`, `exp[4:0]`. Outputs: `e[4:0]`, `f[9:0]`.
- The top level holds the FSM, the edge detector, the shift register and the memory muxing.

## Test plan
- Input 0x0100 (1.0) → memory holds 0x3C00 at [3:2]; `done` at E6+0.
- Input 0x8180 (-1.5) → 0xBE00. Input 0x0001 (2^-8) → 0x1C00 with `done` at E6+14.
- Rounding ties: 0x0801 → 0x4800 (tie, even, round down); 0x0803 → 0x4802 (tie, odd, round up).
- Saturation and zero: 0x7FFF → 0x5800 (mantissa carry into exponent); 0x8000 → 0x8000; 0x0000 → 0x0000.
- Assert `reset` at E3 during a 0x0001 conversion → `done=0` and `dm_we=0` immediately; bytes 2 and 3 are unchanged. A following start yields the correct result.
- Pulse `start` again during NORM → ignored; exactly two writes occur and the result is unchanged.
